// File: rtl/bitty_fetch_ctrl.sv
// bitty_fetch_ctrl: instruction sequencer for bitty_core.
// Walks pc through a synchronous-read instruction memory, latches each word,
// runs the core until a rising edge of done, and stops on HALT_INSTR, on a
// stop request, or on an EXEC watchdog timeout.
// Optional feature macro: BITTY_FETCH_TIMEOUT_EN (EXEC watchdog, sticky error).
module bitty_fetch_ctrl #(
   parameter int          ADDR_W         = 8,
   parameter logic [15:0] HALT_INSTR     = 16'hFFFF,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stop,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd_en,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       instruction,
   output logic              run,
   input  logic              done,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instr_count,
   output logic              error
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic done_q;
   logic done_rise;
   logic stop_pend;
   logic timeout;
   logic launch;

   // Only a 0->1 edge of done marks completion; a level left high from the
   // previous instruction must not retire the next one.
   assign done_rise = done & ~done_q;
   assign launch    = start & ((state == S_IDLE) | (state == S_HALTED));
   assign imem_addr = pc;

`ifdef BITTY_FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             error_q;

   // Watchdog counts EXEC cycles; it is held at zero outside EXEC so every
   // instruction starts from a fresh count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                tmo_cnt <= '0;
      else if (state != S_EXEC) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + 1'b1;
   end

   // A completion in the last allowed cycle wins over the timeout.
   assign timeout = (state == S_EXEC) & ~done_rise &
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Sticky timeout flag, cleared only by a new start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        error_q <= 1'b0;
      else if (launch)  error_q <= 1'b0;
      else if (timeout) error_q <= 1'b1;
   end

   assign error = error_q;
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALTED: if (start) state_nxt = S_FETCH;
         S_FETCH:          state_nxt = S_LOAD;
         S_LOAD: begin
            if (stop_pend)                    state_nxt = S_IDLE;
            else if (imem_rdata == HALT_INSTR) state_nxt = S_HALTED;
            else                              state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (done_rise)    state_nxt = (stop_pend | stop) ? S_IDLE : S_FETCH;
            else if (timeout) state_nxt = S_HALTED;
         end
         default:          state_nxt = S_IDLE;
      endcase
   end

   // Outputs; run drops combinationally on the completion (or timeout) cycle.
   always_comb begin
      imem_rd_en = (state == S_FETCH);
      run        = (state == S_EXEC) & ~done_rise & ~timeout;
      busy       = (state == S_FETCH) | (state == S_LOAD) | (state == S_EXEC);
      halted     = (state == S_HALTED);
   end

   // Datapath: pc, instruction latch, retire counter, stop latch, done delay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         instruction <= '0;
         instr_count <= '0;
         stop_pend   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= done;
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  pc          <= start_addr;
                  instr_count <= '0;
                  stop_pend   <= 1'b0;
               end
            end
            S_FETCH: begin
               if (stop) stop_pend <= 1'b1;
            end
            S_LOAD: begin
               instruction <= imem_rdata;
               if (stop) stop_pend <= 1'b1;
            end
            S_EXEC: begin
               if (stop) stop_pend <= 1'b1;
               if (done_rise) begin
                  instr_count <= instr_count + 16'd1;
                  pc          <= pc + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// Bench for bitty_fetch_ctrl: memory model, 3-run-cycle core model with a
// done override, and a scoreboard monitor for run windows and stop events.
module tb_bitty_fetch_ctrl;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [7:0]  start_addr = 8'h00;
   logic [7:0]  imem_addr, pc;
   logic        imem_rd_en, run, done, busy, halted, error;
   logic [15:0] imem_rdata, instruction, instr_count;
   logic        core_done, ovr_en = 1'b0, ovr_val = 1'b0;
   logic [1:0]  core_cnt;
   logic [15:0] mem [256];

   typedef struct {
      logic        halted;
      logic [7:0]  pc;
      logic [15:0] cnt;
      logic        err;
   } evt_t;

   int   exp_win[$];
   evt_t exp_evt[$];
   int   checks = 0, errors = 0;

   always #5 clk = ~clk;

   bitty_fetch_ctrl dut (
      .clk(clk), .reset(rst), .start(start), .start_addr(start_addr), .stop(stop),
      .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
      .instruction(instruction), .run(run), .done(done), .busy(busy),
      .halted(halted), .pc(pc), .instr_count(instr_count), .error(error)
   );

   // Synchronous-read instruction memory.
   always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

   // Core model: done rises after 3 sampled run cycles and stays high until run.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_done <= 1'b0;
         core_cnt  <= 2'd0;
      end else if (run) begin
         if (core_cnt == 2'd2) begin
            core_done <= 1'b1;
            core_cnt  <= 2'd0;
         end else begin
            core_done <= 1'b0;
            core_cnt  <= core_cnt + 2'd1;
         end
      end else begin
         core_cnt <= 2'd0;
      end
   end

   assign done = ovr_en ? ovr_val : core_done;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] a);
      step();
      start      = 1'b1;
      start_addr = a;
      step();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_not_busy(input int max);
      int n;
      n = 0;
      while (busy && n < max) begin
         step();
         n++;
      end
      check("wait_not_busy", int'(busy), 0);
      step();
   endtask

   task automatic push_evt(input logic h, input logic [7:0] p, input logic [15:0] c, input logic e);
      evt_t ev;
      ev.halted = h;
      ev.pc     = p;
      ev.cnt    = c;
      ev.err    = e;
      exp_evt.push_back(ev);
   endtask

   // Monitor: measures each run window and each busy->idle transition.
   initial begin
      int   win;
      logic prun, pbusy;
      evt_t e;
      win = 0; prun = 1'b0; pbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            win = 0; prun = 1'b0; pbusy = 1'b0;
         end else begin
            if (run) win++;
            else if (prun) begin
               if (exp_win.size() == 0) check("run_window_unexpected", win, 0);
               else                     check("run_window", win, exp_win.pop_front());
               win = 0;
            end
            if (pbusy && !busy) begin
               if (exp_evt.size() == 0) check("stop_event_queue", exp_evt.size(), 1);
               else begin
                  e = exp_evt.pop_front();
                  check("evt_halted", int'(halted), int'(e.halted));
                  check("evt_pc", int'(pc), int'(e.pc));
                  check("evt_count", int'(instr_count), int'(e.cnt));
                  check("evt_error", int'(error), int'(e.err));
               end
            end
            prun  = run;
            pbusy = busy;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int hi, rd, n;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[8'h10] = 16'h0A01; mem[8'h11] = 16'h0A02; mem[8'h12] = 16'h0A03; mem[8'h13] = 16'hFFFF;
      mem[8'h20] = 16'h0B01; mem[8'h21] = 16'h0B02; mem[8'h22] = 16'hFFFF;
      mem[8'hFF] = 16'h5A5A; mem[8'h00] = 16'hFFFF;
      mem[8'h30] = 16'h0C01;

      // Reset state
      repeat (3) step();
      check("rst_run", int'(run), 0);
      check("rst_rd_en", int'(imem_rd_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_halted", int'(halted), 0);
      check("rst_pc", int'(pc), 0);
      check("rst_count", int'(instr_count), 0);
      check("rst_instr", int'(instruction), 0);
      check("rst_error", int'(error), 0);
      rst = 1'b0;
      step();

      // Straight-line program with halt
      repeat (3) exp_win.push_back(3);
      push_evt(1'b1, 8'h13, 16'd3, 1'b0);
      pulse_start(8'h10);
      check("first_rd_en", int'(imem_rd_en), 1);
      repeat (19) step();
      check("halt_not_early", int'(halted), 0);
      step();
      check("halt_at_20", int'(halted), 1);
      check("halt_pc", int'(pc), 'h13);
      check("halt_count", int'(instr_count), 3);
      check("halt_busy", int'(busy), 0);
      step();

      // Stale done: restart from HALTED, done held high into 2nd EXEC
      exp_win.push_back(3);
      exp_win.push_back(7);
      push_evt(1'b1, 8'h22, 16'd2, 1'b0);
      pulse_start(8'h20);
      n = 0;
      while (instr_count != 16'd1 && n < 20) begin step(); n++; end
      check("stale_first_done", int'(instr_count), 1);
      ovr_en = 1'b1; ovr_val = 1'b1;
      step();
      step();
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         if (run) hi++;
         step();
      end
      check("stale_run_held", hi, 6);
      check("stale_no_retire", int'(instr_count), 1);
      ovr_val = 1'b0;
      step();
      ovr_val = 1'b1;
      #1;
      check("stale_rise_run_low", int'(run), 0);
      step();
      check("stale_retired", int'(instr_count), 2);
      ovr_en = 1'b0;
      wait_not_busy(50);

      // Stop during first EXEC
      do_reset();
      exp_win.push_back(3);
      push_evt(1'b0, 8'h11, 16'd1, 1'b0);
      pulse_start(8'h10);
      step();
      step();
      check("exec_instr", int'(instruction), 'h0A01);
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_not_busy(50);
      check("stop_pc", int'(pc), 'h11);
      check("stop_count", int'(instr_count), 1);
      rd = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_rd_en || busy) rd++;
         step();
      end
      check("stop_no_fetch", rd, 0);

      // pc wrap
      do_reset();
      exp_win.push_back(3);
      push_evt(1'b1, 8'h00, 16'd1, 1'b0);
      pulse_start(8'hFF);
      wait_not_busy(50);
      check("wrap_pc", int'(pc), 0);

      // Asynchronous reset mid-EXEC
      do_reset();
      pulse_start(8'h10);
      n = 0;
      while (!run && n < 10) begin step(); n++; end
      check("rst_test_run_seen", int'(run), 1);
      #1 rst = 1'b1;
      #1;
      check("arst_run", int'(run), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_pc", int'(pc), 0);
      check("arst_count", int'(instr_count), 0);
      check("arst_rd_en", int'(imem_rd_en), 0);
      step();
      step();
      rst = 1'b0;
      step();
      repeat (3) exp_win.push_back(3);
      push_evt(1'b1, 8'h13, 16'd3, 1'b0);
      pulse_start(8'h10);
      wait_not_busy(50);

`ifdef BITTY_FETCH_TIMEOUT_EN
      // Watchdog: done never rises
      do_reset();
      ovr_en = 1'b1; ovr_val = 1'b0;
      exp_win.push_back(15);
      push_evt(1'b1, 8'h30, 16'd0, 1'b1);
      pulse_start(8'h30);
      wait_not_busy(100);
      check("tmo_error", int'(error), 1);
      check("tmo_run", int'(run), 0);
      ovr_en = 1'b0;
      repeat (3) exp_win.push_back(3);
      push_evt(1'b1, 8'h13, 16'd3, 1'b0);
      pulse_start(8'h10);
      check("tmo_error_cleared", int'(error), 0);
      wait_not_busy(50);
`endif

      step();
      check("run_queue_empty", exp_win.size(), 0);
      check("evt_queue_empty", exp_evt.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
